// File: rtl/data_ram_responder.sv
// rtl/data_ram_responder.sv - two-port serialising data RAM responder (optional DATA_RAM_CLEAR_EN power-up clear)
module data_ram_responder #(
  parameter int AW    = 8,
  parameter int DW    = 32,
  parameter int DEPTH = 256
) (
  input  logic          iCLK,
  input  logic          iRST,
  input  logic          iRAM_CE_I,
  input  logic          iRAM_RD_I,
  input  logic          iRAM_WR_I,
  input  logic [AW-1:0] iRAM_ADDR_I,
  input  logic [DW-1:0] iRAM_DATA_WR_I,
  output logic [DW-1:0] oRAM_DATA_RD_I,
  output logic          oRAM_VALID_I,
  input  logic          iRAM_CE_S,
  input  logic          iRAM_RD_S,
  input  logic          iRAM_WR_S,
  input  logic [AW-1:0] iRAM_ADDR_S,
  input  logic [DW-1:0] iRAM_DATA_WR_S,
  output logic [DW-1:0] oRAM_DATA_RD_S,
  output logic          oRAM_VALID_S,
  output logic          oRAM_BUSY,
  output logic          oRAM_OVF
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP, ST_CLEAR} state_t;

  logic [DW-1:0] mem [DEPTH];

  state_t        state_q, state_d;
  logic          req_s_q, req_s_d;       // 1: port S owns the active request
  logic          req_wr_q, req_wr_d;
  logic [AW-1:0] req_addr_q, req_addr_d;
  logic [DW-1:0] req_wdata_q, req_wdata_d;
  logic          pnd_vld_q, pnd_vld_d;
  logic          pnd_s_q, pnd_s_d;
  logic          pnd_wr_q, pnd_wr_d;
  logic [AW-1:0] pnd_addr_q, pnd_addr_d;
  logic [DW-1:0] pnd_wdata_q, pnd_wdata_d;
  logic [DW-1:0] rdata_i_q, rdata_i_d;
  logic [DW-1:0] rdata_s_q, rdata_s_d;
  logic          ovf_q, ovf_d;
`ifdef DATA_RAM_CLEAR_EN
  logic [AW-1:0] clr_addr_q, clr_addr_d;
`endif

  logic          vreq_i, vreq_s, any_req, both_req;
  logic          win_wr;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  // Request qualification and fixed S-over-I arbitration of the incoming strobes
  always_comb begin
    vreq_i    = iRAM_CE_I & (iRAM_RD_I ^ iRAM_WR_I);
    vreq_s    = iRAM_CE_S & (iRAM_RD_S ^ iRAM_WR_S);
    any_req   = vreq_i | vreq_s;
    both_req  = vreq_i & vreq_s;
    win_wr    = vreq_s ? iRAM_WR_S : iRAM_WR_I;
    win_addr  = vreq_s ? iRAM_ADDR_S : iRAM_ADDR_I;
    win_wdata = vreq_s ? iRAM_DATA_WR_S : iRAM_DATA_WR_I;
    mem_rdata = mem[req_addr_q];
  end

  // Access FSM next state, request/pending slot steering and memory write port
  always_comb begin
    state_d     = state_q;
    req_s_d     = req_s_q;
    req_wr_d    = req_wr_q;
    req_addr_d  = req_addr_q;
    req_wdata_d = req_wdata_q;
    pnd_vld_d   = pnd_vld_q;
    pnd_s_d     = pnd_s_q;
    pnd_wr_d    = pnd_wr_q;
    pnd_addr_d  = pnd_addr_q;
    pnd_wdata_d = pnd_wdata_q;
    rdata_i_d   = rdata_i_q;
    rdata_s_d   = rdata_s_q;
    ovf_d       = ovf_q;
    mem_we      = 1'b0;
    mem_waddr   = req_addr_q;
    mem_wdata   = req_wdata_q;
`ifdef DATA_RAM_CLEAR_EN
    clr_addr_d  = clr_addr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pnd_vld_q) begin
          // A request parked during the last response goes first
          req_s_d     = pnd_s_q;
          req_wr_d    = pnd_wr_q;
          req_addr_d  = pnd_addr_q;
          req_wdata_d = pnd_wdata_q;
          pnd_vld_d   = 1'b0;
          state_d     = ST_ACCESS;
          if (any_req) begin
            pnd_vld_d   = 1'b1;
            pnd_s_d     = vreq_s;
            pnd_wr_d    = win_wr;
            pnd_addr_d  = win_addr;
            pnd_wdata_d = win_wdata;
            if (both_req) ovf_d = 1'b1;
          end
        end else if (any_req) begin
          req_s_d     = vreq_s;
          req_wr_d    = win_wr;
          req_addr_d  = win_addr;
          req_wdata_d = win_wdata;
          state_d     = ST_ACCESS;
          if (both_req) begin
            pnd_vld_d   = 1'b1;
            pnd_s_d     = 1'b0;
            pnd_wr_d    = iRAM_WR_I;
            pnd_addr_d  = iRAM_ADDR_I;
            pnd_wdata_d = iRAM_DATA_WR_I;
          end
        end
      end
      ST_ACCESS: begin
        if (req_wr_q) mem_we = 1'b1;
        else if (req_s_q) rdata_s_d = mem_rdata;
        else rdata_i_d = mem_rdata;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (pnd_vld_q) begin
          req_s_d     = pnd_s_q;
          req_wr_d    = pnd_wr_q;
          req_addr_d  = pnd_addr_q;
          req_wdata_d = pnd_wdata_q;
          pnd_vld_d   = 1'b0;
          state_d     = ST_ACCESS;
        end else begin
          state_d = ST_IDLE;
        end
      end
`ifdef DATA_RAM_CLEAR_EN
      ST_CLEAR: begin
        mem_we     = 1'b1;
        mem_waddr  = clr_addr_q;
        mem_wdata  = '0;
        clr_addr_d = clr_addr_q + 1'b1;
        if (clr_addr_q == AW'(DEPTH - 1)) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase
    // Arrivals while busy: only the slot (as it stood before this edge) can absorb one
    if (state_q != ST_IDLE && any_req) begin
      if (pnd_vld_q) begin
        ovf_d = 1'b1;
      end else begin
        pnd_vld_d   = 1'b1;
        pnd_s_d     = vreq_s;
        pnd_wr_d    = win_wr;
        pnd_addr_d  = win_addr;
        pnd_wdata_d = win_wdata;
        if (both_req) ovf_d = 1'b1;
      end
    end
  end

  // Control and data registers; reset aborts any access in flight
  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
`ifdef DATA_RAM_CLEAR_EN
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
`else
      state_q    <= ST_IDLE;
`endif
      req_s_q     <= 1'b0;
      req_wr_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      pnd_vld_q   <= 1'b0;
      pnd_s_q     <= 1'b0;
      pnd_wr_q    <= 1'b0;
      pnd_addr_q  <= '0;
      pnd_wdata_q <= '0;
      rdata_i_q   <= '0;
      rdata_s_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
`ifdef DATA_RAM_CLEAR_EN
      clr_addr_q <= clr_addr_d;
`endif
      state_q     <= state_d;
      req_s_q     <= req_s_d;
      req_wr_q    <= req_wr_d;
      req_addr_q  <= req_addr_d;
      req_wdata_q <= req_wdata_d;
      pnd_vld_q   <= pnd_vld_d;
      pnd_s_q     <= pnd_s_d;
      pnd_wr_q    <= pnd_wr_d;
      pnd_addr_q  <= pnd_addr_d;
      pnd_wdata_q <= pnd_wdata_d;
      rdata_i_q   <= rdata_i_d;
      rdata_s_q   <= rdata_s_d;
      ovf_q       <= ovf_d;
    end
  end

  // Storage array; contents deliberately survive reset
  always_ff @(posedge iCLK) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // Acknowledges are decoded from the RESP state and the owning port
  always_comb begin
    oRAM_VALID_I   = (state_q == ST_RESP) && !req_s_q;
    oRAM_VALID_S   = (state_q == ST_RESP) && req_s_q;
    oRAM_BUSY      = (state_q != ST_IDLE) || pnd_vld_q;
    oRAM_OVF       = ovf_q;
    oRAM_DATA_RD_I = rdata_i_q;
    oRAM_DATA_RD_S = rdata_s_q;
  end

endmodule

// File: tb/tb_data_ram_responder.sv
// tb/tb_data_ram_responder.sv - scoreboard bench for data_ram_responder (honours DATA_RAM_CLEAR_EN)
module tb_data_ram_responder;
  localparam int AW = 8;
  localparam int DW = 32;
`ifdef DATA_RAM_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  logic iCLK = 1'b0;
  logic iRST = 1'b1;
  logic iRAM_CE_I = 0, iRAM_RD_I = 0, iRAM_WR_I = 0;
  logic [AW-1:0] iRAM_ADDR_I = '0;
  logic [DW-1:0] iRAM_DATA_WR_I = '0;
  logic iRAM_CE_S = 0, iRAM_RD_S = 0, iRAM_WR_S = 0;
  logic [AW-1:0] iRAM_ADDR_S = '0;
  logic [DW-1:0] iRAM_DATA_WR_S = '0;
  logic [DW-1:0] oRAM_DATA_RD_I, oRAM_DATA_RD_S;
  logic oRAM_VALID_I, oRAM_VALID_S, oRAM_BUSY, oRAM_OVF;

  data_ram_responder #(.AW(AW), .DW(DW), .DEPTH(256)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iRAM_CE_I(iRAM_CE_I), .iRAM_RD_I(iRAM_RD_I), .iRAM_WR_I(iRAM_WR_I),
    .iRAM_ADDR_I(iRAM_ADDR_I), .iRAM_DATA_WR_I(iRAM_DATA_WR_I),
    .oRAM_DATA_RD_I(oRAM_DATA_RD_I), .oRAM_VALID_I(oRAM_VALID_I),
    .iRAM_CE_S(iRAM_CE_S), .iRAM_RD_S(iRAM_RD_S), .iRAM_WR_S(iRAM_WR_S),
    .iRAM_ADDR_S(iRAM_ADDR_S), .iRAM_DATA_WR_S(iRAM_DATA_WR_S),
    .oRAM_DATA_RD_S(oRAM_DATA_RD_S), .oRAM_VALID_S(oRAM_VALID_S),
    .oRAM_BUSY(oRAM_BUSY), .oRAM_OVF(oRAM_OVF)
  );

  always #5 iCLK = ~iCLK;

  int tests = 0;
  int fails = 0;
  logic [DW:0] exp_i_q [$];   // bit DW set: compare read data
  logic [DW:0] exp_s_q [$];
  logic [DW-1:0] model [256];

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard: each acknowledge consumes the oldest expectation of its port
  always @(negedge iCLK) begin
    logic [DW:0] e;
    if (!iRST && oRAM_VALID_I) begin
      if (exp_i_q.size() == 0) check("valid_i_unexpected", DW'(oRAM_VALID_I), '0);
      else begin
        e = exp_i_q.pop_front();
        if (e[DW]) check("rd_i", oRAM_DATA_RD_I, e[DW-1:0]);
      end
    end
    if (!iRST && oRAM_VALID_S) begin
      if (exp_s_q.size() == 0) check("valid_s_unexpected", DW'(oRAM_VALID_S), '0);
      else begin
        e = exp_s_q.pop_front();
        if (e[DW]) check("rd_s", oRAM_DATA_RD_S, e[DW-1:0]);
      end
    end
  end

  task automatic req_s(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    iRAM_CE_S = 1; iRAM_WR_S = wr; iRAM_RD_S = !wr; iRAM_ADDR_S = a; iRAM_DATA_WR_S = d;
    if (wr) begin model[a] = d; exp_s_q.push_back({1'b0, d}); end
    else exp_s_q.push_back({1'b1, model[a]});
  endtask

  task automatic req_i(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d, input bit served);
    iRAM_CE_I = 1; iRAM_WR_I = wr; iRAM_RD_I = !wr; iRAM_ADDR_I = a; iRAM_DATA_WR_I = d;
    if (served) begin
      if (wr) begin model[a] = d; exp_i_q.push_back({1'b0, d}); end
      else exp_i_q.push_back({1'b1, model[a]});
    end
  endtask

  // One rising edge with the current strobes, then all strobes released
  task automatic step();
    @(negedge iCLK);
    iRAM_CE_I = 0; iRAM_RD_I = 0; iRAM_WR_I = 0;
    iRAM_CE_S = 0; iRAM_RD_S = 0; iRAM_WR_S = 0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (oRAM_BUSY && n < 600) begin @(negedge iCLK); n++; end
    check(tag, DW'(oRAM_BUSY), '0);
    @(negedge iCLK);
  endtask

  task automatic release_reset();
    int cnt = 0;
    iRST = 0;
    if (CLR) begin
      while (oRAM_BUSY && cnt < 600) begin cnt++; @(negedge iCLK); end
      check("clear_busy_cycles", DW'(cnt), DW'(256));
      for (int k = 0; k < 256; k++) model[k] = '0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    logic [DW-1:0] d;
    // Reset state
    repeat (2) @(negedge iCLK);
    check("rst_valid_i", DW'(oRAM_VALID_I), '0);
    check("rst_valid_s", DW'(oRAM_VALID_S), '0);
    check("rst_busy", DW'(oRAM_BUSY), DW'(CLR));
    check("rst_ovf", DW'(oRAM_OVF), '0);
    check("rst_rd_i", oRAM_DATA_RD_I, '0);
    check("rst_rd_s", oRAM_DATA_RD_S, '0);
    release_reset();
    if (CLR) begin
      req_i(0, 8'hFF, '0, 1); step();
      wait_idle("clear_read_idle");
    end

    // S write then I read of the same word
    req_s(1, 8'h10, 32'hDEADBEEF); step();
    check("t1_busy", DW'(oRAM_BUSY), 32'd1);
    check("t1_valid_s_early", DW'(oRAM_VALID_S), '0);
    @(negedge iCLK);
    check("t1_valid_s", DW'(oRAM_VALID_S), 32'd1);
    @(negedge iCLK);
    check("t1_valid_s_one_cycle", DW'(oRAM_VALID_S), '0);
    check("t1_idle", DW'(oRAM_BUSY), '0);
    check("t1_write_keeps_rd_s", oRAM_DATA_RD_S, '0);
    req_i(0, 8'h10, '0, 1); step();
    @(negedge iCLK);
    check("t1_valid_i", DW'(oRAM_VALID_I), 32'd1);
    check("t1_data_i", oRAM_DATA_RD_I, 32'hDEADBEEF);
    wait_idle("t1_done");

    // Same-edge S write and I read: S first, I from the pending slot
    req_s(1, 8'h20, 32'h12345678);
    req_i(0, 8'h20, '0, 1); step();
    @(negedge iCLK);
    check("t2_valid_s", DW'(oRAM_VALID_S), 32'd1);
    check("t2_valid_i_wait", DW'(oRAM_VALID_I), '0);
    repeat (2) @(negedge iCLK);
    check("t2_valid_i", DW'(oRAM_VALID_I), 32'd1);
    check("t2_data_i", oRAM_DATA_RD_I, 32'h12345678);
    check("t2_ovf", DW'(oRAM_OVF), '0);
    wait_idle("t2_done");

    // Random write/readback through port S
    for (int k = 0; k < 4; k++) begin
      d = $urandom | 32'h1;
      req_s(1, AW'(8'h40 + k), d); step(); wait_idle("wr_loop");
      req_s(0, AW'(8'h40 + k), '0); step(); wait_idle("rd_loop");
    end

    // RD and WR together is not a request
    req_s(1, 8'h05, 32'h0BADF00D); step(); wait_idle("t4_prep");
    iRAM_CE_S = 1; iRAM_RD_S = 1; iRAM_WR_S = 1; iRAM_ADDR_S = 8'h05; iRAM_DATA_WR_S = 32'hFFFFFFFF;
    step();
    for (int k = 0; k < 3; k++) begin
      check("t4_busy", DW'(oRAM_BUSY), '0);
      check("t4_valid_s", DW'(oRAM_VALID_S), '0);
      @(negedge iCLK);
    end
    req_i(0, 8'h05, '0, 1); step(); wait_idle("t4_read");

    // Reset during an S write in ACCESS aborts it
    req_s(1, 8'h30, 32'h11112222); step(); wait_idle("t5_prep");
    iRAM_CE_S = 1; iRAM_WR_S = 1; iRAM_ADDR_S = 8'h30; iRAM_DATA_WR_S = 32'hAAAA5555;
    step();
    iRST = 1; #1;
    check("t5_busy", DW'(oRAM_BUSY), DW'(CLR));
    check("t5_valid_s", DW'(oRAM_VALID_S), '0);
    check("t5_rd_s", oRAM_DATA_RD_S, '0);
    check("t5_rd_i", oRAM_DATA_RD_I, '0);
    repeat (2) @(negedge iCLK);
    release_reset();
    repeat (3) begin
      check("t5_no_valid", DW'(oRAM_VALID_S), '0);
      @(negedge iCLK);
    end
    req_i(0, 8'h30, '0, 1); step(); wait_idle("t5_read");

    // Three back-to-back I reads: third is dropped and OVF sticks
    for (int k = 1; k <= 3; k++) begin
      req_s(1, AW'(k), 32'hC0DE0000 + k); step(); wait_idle("t6_prep");
    end
    req_i(0, 8'h01, '0, 1); step();
    req_i(0, 8'h02, '0, 1); step();
    check("t6_ovf_early", DW'(oRAM_OVF), '0);
    req_i(0, 8'h03, '0, 0); step();
    check("t6_ovf", DW'(oRAM_OVF), 32'd1);
    wait_idle("t6_done");
    repeat (3) @(negedge iCLK);
    check("t6_ovf_sticky", DW'(oRAM_OVF), 32'd1);
    iRST = 1; repeat (2) @(negedge iCLK);
    check("t6_ovf_reset", DW'(oRAM_OVF), '0);
    release_reset();

    check("sb_empty_i", DW'(exp_i_q.size()), '0);
    check("sb_empty_s", DW'(exp_s_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
